// File: rtl/memory_game_core.sv
// memory_game_core -- sequence-memory game controller.
//
// A sequence of NUM_DIGITS hex digits is shown for a difficulty-dependent
// number of cycles, then the player keys it back. A correct entry scores a
// point and fetches the next sequence. A wrong entry (or an input timeout)
// ends the game, or costs a life when the lives feature is compiled in.
//
// Optional feature: define MEMGAME_LIVES_EN to enable the lives counter.
// With the macro undefined, lives reads 0 and any mismatch ends the game.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    one-cycle strobe qualifying key_value
//   key_value    hex key code
//   seq_in       next sequence from the provider, digit 0 in the MSBs
//   seq_req      one-cycle pulse after each latch of seq_in (provider advance)
//   cur_seq      sequence currently being played
//   show_number  high while cur_seq is to be displayed
//   entry_buf    digits entered so far, newest in the LSBs
//   entry_cnt    number of digits entered so far
//   difficulty   0 EASY, 1 MEDIUM, 2 HARD
//   score        rounds won this game (saturating)
//   lives        remaining attempts
//   state        0 IDLE, 1 SHOW, 2 INPUT, 3 OVER
module memory_game_core #(
   parameter int NUM_DIGITS    = 4,
   parameter int SHOW_EASY     = 7000000,
   parameter int SHOW_MEDIUM   = 5000000,
   parameter int SHOW_HARD     = 3000000,
   parameter int INPUT_TIMEOUT = 0,
   parameter int LIVES         = 3,
   parameter int SCORE_W       = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    key_valid,
   input  logic [3:0]              key_value,
   input  logic [4*NUM_DIGITS-1:0] seq_in,
   output logic                    seq_req,
   output logic [4*NUM_DIGITS-1:0] cur_seq,
   output logic                    show_number,
   output logic [4*NUM_DIGITS-1:0] entry_buf,
   output logic [3:0]              entry_cnt,
   output logic [1:0]              difficulty,
   output logic [SCORE_W-1:0]      score,
   output logic [3:0]              lives,
   output logic [1:0]              state
);

   localparam int BUF_W    = 4 * NUM_DIGITS;
   localparam int SHOW_MAX = (SHOW_EASY > SHOW_MEDIUM) ?
                             ((SHOW_EASY > SHOW_HARD) ? SHOW_EASY : SHOW_HARD) :
                             ((SHOW_MEDIUM > SHOW_HARD) ? SHOW_MEDIUM : SHOW_HARD);
   // Counters only ever hold (limit - 1).
   localparam int CNT_W    = (SHOW_MAX > 1) ? $clog2(SHOW_MAX) : 1;
   localparam int TO_W     = (INPUT_TIMEOUT > 1) ? $clog2(INPUT_TIMEOUT) : 1;

`ifdef MEMGAME_LIVES_EN
   localparam logic [3:0] LIVES_LOAD = 4'(LIVES);
`else
   // Lives compiled out: the counter is parked at zero for the whole game.
   localparam logic [3:0] LIVES_LOAD = 4'(LIVES) & 4'h0;
`endif

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHOW = 2'd1, S_INPUT = 2'd2, S_OVER = 2'd3} state_t;

   state_t             cur_state, state_nxt;
   logic [CNT_W-1:0]   show_cnt, show_cnt_nxt;
   logic [TO_W-1:0]    idle_cnt, idle_cnt_nxt;
   logic               seq_req_nxt, show_nxt;
   logic [BUF_W-1:0]   cur_seq_nxt, entry_buf_nxt, shifted;
   logic [3:0]         entry_cnt_nxt, lives_nxt;
   logic [1:0]         difficulty_nxt;
   logic [SCORE_W-1:0] score_nxt;
   logic               win, miss, timeout_hit;

   // Display length minus one for the given difficulty.
   function automatic logic [CNT_W-1:0] show_load(input logic [1:0] d);
      case (d)
         2'd1:    return CNT_W'(SHOW_MEDIUM - 1);
         2'd2:    return CNT_W'(SHOW_HARD - 1);
         default: return CNT_W'(SHOW_EASY - 1);
      endcase
   endfunction

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= S_IDLE;
         show_cnt    <= '0;
         idle_cnt    <= '0;
         seq_req     <= 1'b0;
         show_number <= 1'b0;
         cur_seq     <= '0;
         entry_buf   <= '0;
         entry_cnt   <= '0;
         difficulty  <= 2'd0;
         score       <= '0;
         lives       <= '0;
      end else begin
         cur_state   <= state_nxt;
         show_cnt    <= show_cnt_nxt;
         idle_cnt    <= idle_cnt_nxt;
         seq_req     <= seq_req_nxt;
         show_number <= show_nxt;
         cur_seq     <= cur_seq_nxt;
         entry_buf   <= entry_buf_nxt;
         entry_cnt   <= entry_cnt_nxt;
         difficulty  <= difficulty_nxt;
         score       <= score_nxt;
         lives       <= lives_nxt;
      end
   end

   assign state = cur_state;

   always_comb begin
      state_nxt      = cur_state;
      show_cnt_nxt   = show_cnt;
      idle_cnt_nxt   = idle_cnt;
      seq_req_nxt    = 1'b0;
      show_nxt       = show_number;
      cur_seq_nxt    = cur_seq;
      entry_buf_nxt  = entry_buf;
      entry_cnt_nxt  = entry_cnt;
      difficulty_nxt = difficulty;
      score_nxt      = score;
      lives_nxt      = lives;
      win            = 1'b0;
      miss           = 1'b0;
      // The completing digit is compared together with the buffer contents.
      shifted        = (entry_buf << 4) | BUF_W'(key_value);
      timeout_hit    = (INPUT_TIMEOUT > 0) && (idle_cnt == TO_W'(INPUT_TIMEOUT - 1));

      case (cur_state)
         S_IDLE: begin
            if (key_valid) begin
               if (key_value >= 4'd1 && key_value <= 4'd3) begin
                  difficulty_nxt = 2'(key_value - 4'd1);
               end else if (key_value == 4'd15) begin
                  cur_seq_nxt   = seq_in;
                  seq_req_nxt   = 1'b1;
                  score_nxt     = '0;
                  lives_nxt     = LIVES_LOAD;
                  entry_buf_nxt = '0;
                  entry_cnt_nxt = '0;
                  state_nxt     = S_SHOW;
                  show_nxt      = 1'b1;
                  show_cnt_nxt  = show_load(difficulty);
               end
            end
         end
         S_SHOW: begin
            if (show_cnt == '0) begin
               state_nxt    = S_INPUT;
               show_nxt     = 1'b0;
               idle_cnt_nxt = '0;
            end else begin
               show_cnt_nxt = show_cnt - 1'b1;
            end
         end
         S_INPUT: begin
            // A key in the expiry cycle wins over the timeout.
            if (key_valid) begin
               idle_cnt_nxt = '0;
               if (key_value <= 4'd9) begin
                  if (entry_cnt + 4'd1 == 4'(NUM_DIGITS)) begin
                     win  = (shifted == cur_seq);
                     miss = (shifted != cur_seq);
                  end else begin
                     entry_buf_nxt = shifted;
                     entry_cnt_nxt = entry_cnt + 4'd1;
                  end
               end else if (key_value == 4'd14) begin
                  entry_buf_nxt = '0;
                  entry_cnt_nxt = '0;
               end
            end else if (timeout_hit) begin
               miss = 1'b1;
            end else if (INPUT_TIMEOUT > 0) begin
               idle_cnt_nxt = idle_cnt + 1'b1;
            end
         end
         S_OVER: begin
            if (key_valid && key_value == 4'd15) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (win) begin
         score_nxt     = sat_inc(score);
         cur_seq_nxt   = seq_in;
         seq_req_nxt   = 1'b1;
         entry_buf_nxt = '0;
         entry_cnt_nxt = '0;
         state_nxt     = S_SHOW;
         show_nxt      = 1'b1;
         show_cnt_nxt  = show_load(difficulty);
      end

      if (miss) begin
         entry_buf_nxt = '0;
         entry_cnt_nxt = '0;
`ifdef MEMGAME_LIVES_EN
         // Replay the same sequence; the provider is not advanced.
         if (lives > 4'd1) begin
            lives_nxt    = lives - 4'd1;
            state_nxt    = S_SHOW;
            show_nxt     = 1'b1;
            show_cnt_nxt = show_load(difficulty);
         end else begin
            lives_nxt = '0;
            state_nxt = S_OVER;
         end
`else
         state_nxt = S_OVER;
`endif
      end
   end

endmodule
